// File: rtl/floo_inorder_rob.sv
// In-order reorder buffer: slots are reserved in issue order, filled by
// out-of-order responses, and drained strictly in allocation order.
module floo_inorder_rob #(
  parameter int unsigned Depth     = 8,
  parameter int unsigned DataWidth = 32,
  localparam int unsigned IdxWidth = $clog2(Depth)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  // slot reservation
  input  logic                 alloc_valid_i,
  output logic                 alloc_ready_o,
  output logic [IdxWidth-1:0]  alloc_idx_o,
  // out-of-order responses
  input  logic                 rsp_valid_i,
  output logic                 rsp_ready_o,
  input  logic [IdxWidth-1:0]  rsp_idx_i,
  input  logic [DataWidth-1:0] rsp_data_i,
  // in-order output
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic [DataWidth-1:0] out_data_o,
  // status
  output logic                 full_o,
  output logic                 empty_o,
  output logic                 err_o
);

  localparam logic [IdxWidth:0] DepthCnt = (IdxWidth+1)'(Depth);

  logic [IdxWidth-1:0]  head_q, head_d;
  logic [IdxWidth-1:0]  tail_q, tail_d;
  logic [IdxWidth:0]    count_q, count_d;
  logic [Depth-1:0]     alloc_q, alloc_d;
  logic [Depth-1:0]     filled_q, filled_d;
  logic [DataWidth-1:0] data_q [Depth];
  logic                 err_q, err_d;

  logic alloc_fire;
  logic release_fire;
  logic rsp_hit;
  logic rsp_bad;
  logic head_valid;

  // Handshake qualification and slot classification of the incoming response
  always_comb begin
    alloc_ready_o = (count_q < DepthCnt);
    alloc_fire    = alloc_valid_i & alloc_ready_o;
    head_valid    = alloc_q[head_q] & filled_q[head_q];
    release_fire  = head_valid & out_ready_i;
    rsp_hit       = rsp_valid_i & alloc_q[rsp_idx_i] & ~filled_q[rsp_idx_i];
    rsp_bad       = rsp_valid_i & ~(alloc_q[rsp_idx_i] & ~filled_q[rsp_idx_i]);
  end

  assign alloc_idx_o = tail_q;
  assign rsp_ready_o = 1'b1;
  assign out_valid_o = head_valid;
  assign out_data_o  = head_valid ? data_q[head_q] : '0;
  assign full_o      = (count_q == DepthCnt);
  assign empty_o     = (count_q == '0);
  assign err_o       = err_q;

  // Next-state for pointers, counters and per-slot flags.
  // Alloc, release and a valid response never target the same slot in one
  // cycle (tail slot is free when alloc fires, head slot is filled when it
  // releases), so the update order below is irrelevant.
  always_comb begin
    head_d   = head_q;
    tail_d   = tail_q;
    count_d  = count_q;
    alloc_d  = alloc_q;
    filled_d = filled_q;
    err_d    = err_q | rsp_bad;

    if (release_fire) begin
      alloc_d[head_q]  = 1'b0;
      filled_d[head_q] = 1'b0;
      head_d           = head_q + IdxWidth'(1);
    end
    if (alloc_fire) begin
      alloc_d[tail_q]  = 1'b1;
      filled_d[tail_q] = 1'b0;
      tail_d           = tail_q + IdxWidth'(1);
    end
    if (rsp_hit) begin
      filled_d[rsp_idx_i] = 1'b1;
    end

    case ({alloc_fire, release_fire})
      2'b10:   count_d = count_q + (IdxWidth+1)'(1);
      2'b01:   count_d = count_q - (IdxWidth+1)'(1);
      default: count_d = count_q;
    endcase
  end

  // Control state register with synchronous reset
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      head_q   <= '0;
      tail_q   <= '0;
      count_q  <= '0;
      alloc_q  <= '0;
      filled_q <= '0;
      err_q    <= 1'b0;
    end else begin
      head_q   <= head_d;
      tail_q   <= tail_d;
      count_q  <= count_d;
      alloc_q  <= alloc_d;
      filled_q <= filled_d;
      err_q    <= err_d;
    end
  end

  // Payload storage; contents are only observable once the filled bit is set
  always_ff @(posedge clk_i) begin
    if (!rst_i && rsp_hit) begin
      data_q[rsp_idx_i] <= rsp_data_i;
    end
  end

endmodule

// File: tb/tb_floo_inorder_rob.sv
// Directed self-checking bench for floo_inorder_rob (Depth=8, DataWidth=32).
module tb_floo_inorder_rob;

  localparam int unsigned Depth     = 8;
  localparam int unsigned DataWidth = 32;
  localparam int unsigned IdxWidth  = $clog2(Depth);

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 alloc_valid = 1'b0;
  logic                 alloc_ready;
  logic [IdxWidth-1:0]  alloc_idx;
  logic                 rsp_valid = 1'b0;
  logic                 rsp_ready;
  logic [IdxWidth-1:0]  rsp_idx = '0;
  logic [DataWidth-1:0] rsp_data = '0;
  logic                 out_valid;
  logic                 out_ready = 1'b0;
  logic [DataWidth-1:0] out_data;
  logic                 full;
  logic                 empty;
  logic                 err;

  int unsigned tests_run = 0;
  int unsigned tests_failed = 0;

  floo_inorder_rob #(
    .Depth     (Depth),
    .DataWidth (DataWidth)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .alloc_valid_i (alloc_valid),
    .alloc_ready_o (alloc_ready),
    .alloc_idx_o   (alloc_idx),
    .rsp_valid_i   (rsp_valid),
    .rsp_ready_o   (rsp_ready),
    .rsp_idx_i     (rsp_idx),
    .rsp_data_i    (rsp_data),
    .out_valid_o   (out_valid),
    .out_ready_i   (out_ready),
    .out_data_o    (out_data),
    .full_o        (full),
    .empty_o       (empty),
    .err_o         (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Advance one cycle; sample/drive point is 1 time unit after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    alloc_valid = 1'b0;
    rsp_valid   = 1'b0;
    rsp_idx     = '0;
    rsp_data    = '0;
    out_ready   = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic alloc_n(input int unsigned n);
    alloc_valid = 1'b1;
    for (int unsigned i = 0; i < n; i++) tick();
    alloc_valid = 1'b0;
  endtask

  task automatic respond(input logic [IdxWidth-1:0] idx, input logic [31:0] d);
    rsp_valid = 1'b1;
    rsp_idx   = idx;
    rsp_data  = d;
    tick();
    rsp_valid = 1'b0;
  endtask

  int unsigned rsp_order [4] = '{3, 1, 0, 2};

  initial begin
    // ---------------- reset state ----------------
    idle_inputs();
    rst = 1'b1;
    tick();
    tick();
    check("rst_alloc_ready", alloc_ready, 1);
    check("rst_alloc_idx",   alloc_idx,   0);
    check("rst_out_valid",   out_valid,   0);
    check("rst_out_data",    out_data,    0);
    check("rst_full",        full,        0);
    check("rst_empty",       empty,       1);
    check("rst_err",         err,         0);
    check("rsp_ready",       rsp_ready,   1);
    rst = 1'b0;
    tick();

    // ---------------- out-of-order responses, in-order drain ----------------
    alloc_valid = 1'b1;
    for (int unsigned i = 0; i < 4; i++) begin
      check("a_alloc_idx", alloc_idx, i);
      tick();
    end
    alloc_valid = 1'b0;
    check("a_not_empty", empty, 0);
    for (int unsigned k = 0; k < 4; k++) begin
      rsp_valid = 1'b1;
      rsp_idx   = IdxWidth'(rsp_order[k]);
      rsp_data  = 32'hD0 + rsp_order[k];
      // head (slot 0) becomes visible only after its response has been stored
      check("a_head_visible", out_valid, (k == 3) ? 1 : 0);
      tick();
    end
    rsp_valid = 1'b0;
    check("a_err", err, 0);
    out_ready = 1'b1;
    for (int unsigned k = 0; k < 4; k++) begin
      check("a_out_valid", out_valid, 1);
      check("a_out_data",  out_data,  32'hD0 + k);
      tick();
    end
    out_ready = 1'b0;
    check("a_end_valid", out_valid, 0);
    check("a_end_data",  out_data,  0);
    check("a_end_empty", empty,     1);

    // ---------------- full, no bypass, resume after release ----------------
    do_reset();
    alloc_valid = 1'b1;
    for (int unsigned i = 0; i < Depth; i++) begin
      check("b_alloc_idx", alloc_idx, i);
      tick();
    end
    check("b_full",        full,        1);
    check("b_alloc_ready", alloc_ready, 0);
    check("b_idx_wrapped", alloc_idx,   0);
    respond(0, 32'h100);
    check("b_out_valid",   out_valid,   1);
    check("b_out_data",    out_data,    32'h100);
    check("b_still_full",  full,        1);
    out_ready = 1'b1;
    check("b_no_bypass",   alloc_ready, 0);
    tick();
    out_ready = 1'b0;
    check("b_rel_full",    full,        0);
    check("b_rel_ready",   alloc_ready, 1);
    check("b_rel_idx",     alloc_idx,   0);
    check("b_rel_valid",   out_valid,   0);
    tick();
    alloc_valid = 1'b0;
    check("b_refull",      full,        1);
    check("b_next_idx",    alloc_idx,   1);

    // ---------------- protocol errors ----------------
    do_reset();
    respond(5, 32'h55);
    check("c_err_unalloc", err,       1);
    check("c_valid",       out_valid, 0);
    check("c_empty",       empty,     1);
    tick();
    tick();
    check("c_err_sticky",  err,       1);
    do_reset();
    check("c_err_cleared", err,       0);
    alloc_n(1);
    respond(0, 32'h11);
    check("c_err_clean",   err,       0);
    check("c_first_data",  out_data,  32'h11);
    respond(0, 32'h22);
    check("c_err_refill",  err,       1);
    check("c_keep_valid",  out_valid, 1);
    check("c_keep_data",   out_data,  32'h11);

    // ---------------- backpressure holds output stable ----------------
    do_reset();
    alloc_n(1);
    respond(0, 32'hAA);
    for (int unsigned i = 0; i < 10; i++) begin
      check("d_hold_valid", out_valid, 1);
      check("d_hold_data",  out_data,  32'hAA);
      tick();
    end
    out_ready = 1'b1;
    check("d_rel_valid", out_valid, 1);
    tick();
    out_ready = 1'b0;
    check("d_released",  out_valid, 0);
    check("d_empty",     empty,     1);

    // ---------------- pointer wrap over 20 rounds ----------------
    do_reset();
    for (int unsigned r = 0; r < 20; r++) begin
      alloc_valid = 1'b1;
      check("e_alloc_idx", alloc_idx, r % Depth);
      tick();
      alloc_valid = 1'b0;
      respond(IdxWidth'(r % Depth), 32'h1000 + r);
      check("e_out_valid", out_valid, 1);
      check("e_out_data",  out_data,  32'h1000 + r);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
    end
    check("e_err",   err,   0);
    check("e_empty", empty, 1);

    // ---------------- concurrent alloc and release ----------------
    do_reset();
    alloc_n(2);
    respond(0, 32'h77);
    alloc_valid = 1'b1;
    out_ready   = 1'b1;
    check("g_valid", out_valid, 1);
    check("g_idx",   alloc_idx, 2);
    tick();
    alloc_valid = 1'b0;
    out_ready   = 1'b0;
    check("g_idx_next", alloc_idx, 3);
    check("g_valid2",   out_valid, 0);
    check("g_empty",    empty,     0);
    alloc_n(5);
    check("g_not_full", full, 0);
    alloc_n(1);
    check("g_full",     full, 1);

    // ---------------- reset with traffic in flight ----------------
    do_reset();
    alloc_n(5);
    respond(0, 32'hF0);
    respond(1, 32'hF1);
    check("f_pre_valid", out_valid, 1);
    check("f_pre_data",  out_data,  32'hF0);
    respond(6, 32'hEE);
    check("f_pre_err",   err,       1);
    rst         = 1'b1;
    alloc_valid = 1'b1;
    out_ready   = 1'b1;
    rsp_valid   = 1'b1;
    rsp_idx     = 2;
    rsp_data    = 32'hF2;
    tick();
    check("f_empty", empty,       1);
    check("f_valid", out_valid,   0);
    check("f_idx",   alloc_idx,   0);
    check("f_err",   err,         0);
    check("f_data",  out_data,    0);
    check("f_ready", alloc_ready, 1);
    check("f_full",  full,        0);
    idle_inputs();
    rst = 1'b0;
    tick();
    check("f_post_empty", empty, 1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
